// File: rtl/mmio_peripheral.sv
// mmio_peripheral: data-bus MMIO responder with reload timer/irq, LED and 7-seg registers.
// Define MMIO_SYSTICK_EN to add the free-running SYSTICK counter at offset 0x14.
module mmio_peripheral #(
    parameter logic [31:0] BASE_ADDR = 32'h40000000,
    parameter int unsigned LED_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          Address,
    input  logic [31:0]          Write_data,
    input  logic                 MemRead,
    input  logic                 MemWrite,
    output logic [31:0]          Read_data,
    output logic                 Hit,
    output logic [LED_WIDTH-1:0] leds,
    output logic [11:0]          digits,
    output logic                 irq
);
    logic [31:0] th, tl, systick;
    logic [2:0]  tcon;
    logic [5:0]  off;
    logic        wr, ovf, set_st, unused_addr;

    assign Hit         = Address[31:8] == BASE_ADDR[31:8];
    assign off         = Address[7:2];
    assign wr          = Hit & MemWrite;
    assign ovf         = tcon[0] & (&tl);
    assign set_st      = ovf & tcon[1];
    assign irq         = tcon[1] & tcon[2];
    assign unused_addr = ^Address[1:0];

    assign Read_data = !(Hit && MemRead) ? 32'h0 :
                       off == 6'h0 ? th :
                       off == 6'h1 ? tl :
                       off == 6'h2 ? {29'h0, tcon} :
                       off == 6'h3 ? 32'(leds) :
                       off == 6'h4 ? {20'h0, digits} :
                       off == 6'h5 ? systick : 32'h0;

    // A software TL write beats count/reload; an overflow status set beats a TCON clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            th     <= 32'h0;
            tl     <= 32'h0;
            tcon   <= 3'h0;
            leds   <= '0;
            digits <= 12'h0;
        end else begin
            if (wr && off == 6'h0) th <= Write_data;
            if (wr && off == 6'h1) tl <= Write_data;
            else if (tcon[0]) tl <= ovf ? th : tl + 32'h1;
            tcon <= (wr && off == 6'h2) ? {Write_data[2] | set_st, Write_data[1:0]}
                                         : {tcon[2] | set_st, tcon[1:0]};
            if (wr && off == 6'h3) leds <= Write_data[LED_WIDTH-1:0];
            if (wr && off == 6'h4) digits <= Write_data[11:0];
        end
    end

`ifdef MMIO_SYSTICK_EN
    always_ff @(posedge clk) systick <= reset ? 32'h0 : systick + 32'h1;
`else
    assign systick = 32'h0;
`endif
endmodule

// File: tb/tb_mmio_peripheral.sv
// tb_mmio_peripheral: directed table vectors plus timer/reset/systick sequences for mmio_peripheral.
module tb_mmio_peripheral;
    localparam logic [31:0] B = 32'h40000000;
`ifdef MMIO_SYSTICK_EN
    localparam bit ST = 1'b1;
`else
    localparam bit ST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, MemRead, MemWrite, Hit, irq;
    logic [31:0] Address, Write_data, Read_data;
    logic [7:0]  leds;
    logic [11:0] digits;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    mmio_peripheral dut (
        .clk(clk), .reset(reset), .Address(Address), .Write_data(Write_data),
        .MemRead(MemRead), .MemWrite(MemWrite), .Read_data(Read_data), .Hit(Hit),
        .leds(leds), .digits(digits), .irq(irq)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rd;
        logic        wr;
        logic [31:0] exp_rd;
        logic        exp_hit;
        logic [7:0]  exp_leds;
        logic [11:0] exp_dig;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic r, input logic w);
        Address    = a;
        Write_data = d;
        MemRead    = r;
        MemWrite   = w;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        drive(a, d, 1'b0, 1'b1);
        tick();
        drive(32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic load(input string name, input logic [31:0] a, input logic [31:0] exp);
        drive(a, 32'h0, 1'b1, 1'b0);
        #1;
        chk(name, Read_data, exp);
        MemRead = 1'b0;
    endtask

    task automatic add(input logic [31:0] a, input logic [31:0] d, input logic r, input logic w,
                       input logic [31:0] er, input logic eh, input logic [7:0] el, input logic [11:0] ed);
        vec_t v;
        v.addr = a; v.wdata = d; v.rd = r; v.wr = w;
        v.exp_rd = er; v.exp_hit = eh; v.exp_leds = el; v.exp_dig = ed;
        vecs.push_back(v);
    endtask

    initial begin
        // Outputs are checked before the edge, so leds/digits reflect earlier vectors.
        add(B + 32'h00, 32'h0, 1, 0, 32'h0, 1, 8'h00, 12'h000);
        add(B + 32'h04, 32'h0, 1, 0, 32'h0, 1, 8'h00, 12'h000);
        add(B + 32'h08, 32'h0, 1, 0, 32'h0, 1, 8'h00, 12'h000);
        add(B + 32'h0C, 32'h0, 1, 0, 32'h0, 1, 8'h00, 12'h000);
        add(B + 32'h10, 32'h0, 1, 0, 32'h0, 1, 8'h00, 12'h000);
        add(B + 32'h18, 32'h0, 1, 0, 32'h0, 1, 8'h00, 12'h000);
        add(B + 32'h0C, 32'hA5, 0, 1, 32'h0, 1, 8'h00, 12'h000);
        add(B + 32'h10, 32'hF3F, 0, 1, 32'h0, 1, 8'hA5, 12'h000);
        add(B + 32'h0C, 32'h0, 1, 0, 32'hA5, 1, 8'hA5, 12'hF3F);
        add(B + 32'h10, 32'h0, 1, 0, 32'hF3F, 1, 8'hA5, 12'hF3F);
        add(32'h10000000, 32'h0, 1, 0, 32'h0, 0, 8'hA5, 12'hF3F);
        add(32'h1000000C, 32'hFF, 0, 1, 32'h0, 0, 8'hA5, 12'hF3F);
        add(B + 32'h0C, 32'h0, 1, 0, 32'hA5, 1, 8'hA5, 12'hF3F);
        add(B + 32'h0C, 32'hFFFFFF5A, 0, 1, 32'h0, 1, 8'hA5, 12'hF3F);
        add(B + 32'h0C, 32'h0, 1, 0, 32'h5A, 1, 8'h5A, 12'hF3F);
        add(B + 32'h0E, 32'h0, 1, 0, 32'h5A, 1, 8'h5A, 12'hF3F);
        add(B + 32'h10, 32'hFFFFF123, 0, 1, 32'h0, 1, 8'h5A, 12'hF3F);
        add(B + 32'h10, 32'h0, 1, 0, 32'h123, 1, 8'h5A, 12'h123);
        add(B + 32'h100, 32'h0, 1, 0, 32'h0, 0, 8'h5A, 12'h123);

        reset = 1'b1;
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        load("reset systick", B + 32'h14, 32'h0);
        chk("reset irq", 32'(irq), 32'h0);
        chk("reset leds", 32'(leds), 32'h0);
        chk("reset digits", 32'(digits), 32'h0);

        foreach (vecs[i]) begin
            drive(vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].wr);
            #1;
            chk($sformatf("v%0d rdata", i), Read_data, vecs[i].exp_rd);
            chk($sformatf("v%0d hit", i), 32'(Hit), 32'(vecs[i].exp_hit));
            chk($sformatf("v%0d leds", i), 32'(leds), 32'(vecs[i].exp_leds));
            chk($sformatf("v%0d digits", i), 32'(digits), 32'(vecs[i].exp_dig));
            tick();
        end
        drive(32'h0, 32'h0, 1'b0, 1'b0);

        store(B + 32'h00, 32'hFFFFFFFC);
        store(B + 32'h04, 32'hFFFFFFFE);
        store(B + 32'h08, 32'h3);
        load("tl start", B + 32'h04, 32'hFFFFFFFE);
        tick();
        load("tl +1", B + 32'h04, 32'hFFFFFFFF);
        tick();
        load("tl reload", B + 32'h04, 32'hFFFFFFFC);
        load("tcon ovf", B + 32'h08, 32'h7);
        chk("irq ovf", 32'(irq), 32'h1);
        store(B + 32'h08, 32'h3);
        chk("irq cleared", 32'(irq), 32'h0);
        load("tcon cleared", B + 32'h08, 32'h3);
        load("tl after clear", B + 32'h04, 32'hFFFFFFFD);
        tick();
        tick();
        store(B + 32'h08, 32'h3);
        load("tcon set wins", B + 32'h08, 32'h7);
        chk("irq set wins", 32'(irq), 32'h1);
        load("tl ovf reload", B + 32'h04, 32'hFFFFFFFC);
        tick();
        tick();
        tick();
        load("tl pre write", B + 32'h04, 32'hFFFFFFFF);
        store(B + 32'h04, 32'h5);
        load("tl write wins", B + 32'h04, 32'h5);
        store(B + 32'h04, 32'hFFFFFFFF);
        store(B + 32'h00, 32'h100);
        load("reload old th", B + 32'h04, 32'hFFFFFFFC);
        load("th new", B + 32'h00, 32'h100);

        store(B + 32'h08, 32'h1);
        store(B + 32'h04, 32'hFFFFFFFF);
        tick();
        load("no status w/o ie", B + 32'h08, 32'h1);
        load("tl reload no ie", B + 32'h04, 32'h100);
        chk("irq no ie", 32'(irq), 32'h0);
        store(B + 32'h08, 32'h0);
        tick();
        load("tl holds", B + 32'h04, 32'h101);
        store(B + 32'h08, 32'h6);
        chk("irq sw set", 32'(irq), 32'h1);
        store(B + 32'h08, 32'h2);
        chk("irq sw clr", 32'(irq), 32'h0);

        drive(B + 32'h04, 32'h77, 1'b1, 1'b1);
        #1;
        chk("rw pre-write", Read_data, 32'h101);
        tick();
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        load("rw post-write", B + 32'h04, 32'h77);

        store(B + 32'h04, 32'hFFFFFFFF);
        store(B + 32'h08, 32'h3);
        tick();
        chk("irq before reset", 32'(irq), 32'h1);
        drive(B + 32'h0C, 32'hFF, 1'b0, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        load("rst tl", B + 32'h04, 32'h0);
        load("rst tcon", B + 32'h08, 32'h0);
        load("rst th", B + 32'h00, 32'h0);
        chk("rst irq", 32'(irq), 32'h0);
        chk("rst leds", 32'(leds), 32'h0);
        chk("rst digits", 32'(digits), 32'h0);
        tick();
        load("rst tl holds", B + 32'h04, 32'h0);

        tick();
        tick();
        tick();
        tick();
        store(B + 32'h14, 32'h1234);
        load("systick 6", B + 32'h14, ST ? 32'h6 : 32'h0);
        tick();
        load("systick 7", B + 32'h14, ST ? 32'h7 : 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mmio_peripheral.md
Name: mmio_peripheral

Overview:
- Memory-mapped peripheral responder on the processor's data-memory bus.
- Decodes processor load/store accesses in a fixed address window and serves them from the block's registers:
  - a reloadable timer with interrupt request,
  - an LED register,
  - a 7-segment digit register,
  - an optional free-running systick counter.
- Sits beside DataMemory; the top level selects between this block's Read_data and DataMemory's Read_data using Hit.

Parameters:
- BASE_ADDR, 32'h40000000, window base; window is BASE_ADDR[31:8] match (256 bytes).
- LED_WIDTH, 8, width of LED register and leds port.

Ports:
- clk  input  1  system clock; all state updates on posedge clk.
- reset  input  1  synchronous, active-high reset.
- Address  input  32  byte address from ALU result; bits [1:0] ignored.
- Write_data  input  32  store data.
- MemRead  input  1  load strobe.
- MemWrite  input  1  store strobe, sampled at posedge.
- Read_data  output  32  combinational load data.
- Hit  output  1  combinational; 1 when Address[31:8]==BASE_ADDR[31:8].
- leds  output  LED_WIDTH  LED register.
- digits  output  12  {an[3:0], seg[7:0]} 7-segment register.
- irq  output  1  timer interrupt request.

Behaviour:
- Register map, offset = Address[7:0] with [1:0] ignored:
  - 0x00 TH (32-bit reload value), R/W.
  - 0x04 TL (32-bit counter), R/W.
  - 0x08 TCON, 3 bits used:
    - [0] timer enable;
    - [1] irq enable;
    - [2] irq status.
    - Upper bits read 0.
  - 0x0C LED, low LED_WIDTH bits, R/W; upper bits read 0.
  - 0x10 DIGITS, low 12 bits, R/W.
  - 0x14 SYSTICK, read-only; writes ignored.
  - Any other offset reads 32'h0; writes ignored.
- Reads:
  - Read_data = selected register when Hit & MemRead, else 32'h0.
  - Zero latency (same cycle), matching DataMemory timing.
- Writes:
  - Take effect at the posedge where Hit & MemWrite.
  - Not Hit: no state change.
- Reset: TH, TL, TCON, LED, DIGITS, SYSTICK all 0.
  - Consequently leds=0, digits=0, irq=0.
  - Reset overrides every write and count in the same cycle.
- Timer, each posedge with TCON[0]=1:
  - if TL==32'hFFFFFFFF: TL<=TH, and if TCON[1]=1 then TCON[2]<=1;
  - else TL<=TL+1.
  - Wrap is modulo 2^32; no other arithmetic.
  - TCON[0]=0: TL holds; TCON[2] is not set.
- Simultaneous events, same posedge:
  - Software write to TL beats the count/reload; TL takes Write_data.
  - Software write to TH: reload in that same cycle uses the old TH.
  - Software write to TCON while overflow sets status:
    - bits [1:0] take Write_data[1:0];
    - TCON[2] <= Write_data[2] | (overflow & old TCON[1]).
    - Set wins, so no interrupt is lost.
- Interrupt status:
  - TCON[2] is cleared only by writing 0 to it or by reset.
  - Writing 1 to TCON[2] sets it (software-triggered interrupt).
- irq:
  - Registered-state combinational: irq = TCON[1] & TCON[2].
  - Rises the cycle after the overflow posedge.
- Reset mid-operation: counter stops; all state is zero on the next cycle; no partial write survives.
- MemRead and MemWrite both 1: write performs as above; Read_data shows the pre-write value.

Optional Feature:
- Macro: MMIO_SYSTICK_EN.
- Defined:
  - SYSTICK increments by 1 every non-reset posedge, wrapping at 2^32;
  - offset 0x14 returns its value.
- Undefined:
  - no SYSTICK register is synthesized;
  - offset 0x14 reads 32'h0 like an unmapped offset.

Test Plan:
- Reset, then read offsets 0x00–0x14 at 0x40000000 -> every Read_data = 0; Hit=1; leds=0, digits=0, irq=0.
- Store 0x000000A5 to 0x4000000C; store 0x00000F3F to 0x40000010; load both back -> leds=8'hA5, digits=12'hF3F, Read_data matches; load 0x10000000 -> Hit=0, Read_data=0, leds unchanged.
- TH=0xFFFFFFFC, TL=0xFFFFFFFE, TCON=3:
  - TL reads 0xFFFFFFFF after 1 cycle;
  - TL reads 0xFFFFFFFC after 2 cycles, with TCON=7 and irq=1;
  - store TCON=3 -> irq=0 next cycle.
- Overflow posedge coincides with store TCON=3 (clear attempt) -> TCON reads 7, irq stays 1; a store to TL on an overflow cycle with value 0x5 -> TL=0x5.
- Assert reset for 1 cycle while timer runs with irq=1 -> next cycle TL=0, TCON=0, irq=0, TL holds at 0.
- With MMIO_SYSTICK_EN: after reset release, read 0x40000014 N cycles later -> N; store 0x1234 to 0x14 has no effect. Without it -> always 0.
